// File: rtl/seq_radix4_booth_mult.sv
`default_nettype none
// ============================================================================
//  Module   : seq_radix4_booth_mult
//  Purpose  : Iterative radix-4 Booth multiplier. One Booth digit is
//             retired per clock over K = N/2+1 digits of the (N+2)-bit
//             extended multiplier. Signed or unsigned is selected per
//             operation and latched at accept. Valid/ready on both sides.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1    clock, rising edge
//    reset      in   1    asynchronous, active-low; clears all state
//    flush      in   1    synchronous abort of any operation in flight
//    in_valid   in   1    operands present
//    in_ready   out  1    block can accept operands (IDLE only)
//    in_a       in   N    multiplicand
//    in_b       in   N    multiplier
//    in_signed  in   1    1: two's-complement operands, 0: unsigned
//    out_valid  out  1    result/overflow valid (DONE only)
//    out_ready  in   1    consumer takes result
//    result     out  2N   product (low 2N bits of the exact product)
//    overflow   out  1    product does not fit in N bits
// ============================================================================
module seq_radix4_booth_mult #(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           flush,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   in_a,
    input  logic [N-1:0]   in_b,
    input  logic           in_signed,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] result,
    output logic           overflow
);

    localparam int K  = N / 2 + 1;          // Booth digits per product
    localparam int EW = N + 2;              // extended operand width
    localparam int HW = N + 4;              // upper accumulator width (holds hi +/- 2A)
    localparam int CW = $clog2(K + 1);      // digit counter width (counts 0..K)
    localparam logic [CW-1:0] LAST = CW'(K);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [EW-1:0]    a_q, a_d;
    logic [EW-1:0]    m_q, m_d;        // multiplier, low product bits shift in from the top
    logic             bprev_q, bprev_d;
    logic [HW-1:0]    hi_q, hi_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             signed_q, signed_d;
    logic [2*N-1:0]   result_q, result_d;
    logic             ovf_q, ovf_d;

    logic [HW-1:0]    a_ext;
    logic [HW-1:0]    a2_ext;
    logic [HW-1:0]    sel;
    logic [HW-1:0]    sum;
    logic [2*N-1:0]   prod;
    logic [N:0]       prod_top;
    logic             prod_ovf;

    // Booth digit select from {b[2i+1], b[2i], b[2i-1]}
    always_comb begin
        a_ext  = {{2{a_q[EW-1]}}, a_q};
        a2_ext = {a_q[EW-1], a_q, 1'b0};
        sel    = '0;
        unique case ({m_q[1:0], bprev_q})
            3'b001, 3'b010: sel = a_ext;
            3'b011:         sel = a2_ext;
            3'b100:         sel = -a2_ext;
            3'b101, 3'b110: sel = -a_ext;
            default:        sel = '0;
        endcase
        sum = hi_q + sel;
    end

    // After K digits the full product is {hi_q, m_q}; keep its low 2N bits.
    always_comb begin
        prod     = {hi_q[N-3:0], m_q};
        prod_top = prod[2*N-1:N-1];
        if (signed_q) begin
            prod_ovf = !((&prod_top) || !(|prod_top));
        end else begin
            prod_ovf = |prod[2*N-1:N];
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        m_d      = m_q;
        bprev_d  = bprev_q;
        hi_d     = hi_q;
        cnt_d    = cnt_q;
        signed_d = signed_q;
        result_d = result_q;
        ovf_d    = ovf_q;

        if (flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_d      = in_signed ? {{2{in_a[N-1]}}, in_a} : {2'b00, in_a};
                        m_d      = in_signed ? {{2{in_b[N-1]}}, in_b} : {2'b00, in_b};
                        bprev_d  = 1'b0;
                        hi_d     = '0;
                        cnt_d    = '0;
                        signed_d = in_signed;
                        state_d  = CALC;
                    end
                end
                CALC: begin
                    if (cnt_q == LAST) begin
                        // All digits retired: register the product on the way into DONE.
                        result_d = prod;
                        ovf_d    = prod_ovf;
                        state_d  = DONE;
                    end else begin
                        // Add the digit, then arithmetic-shift {hi, m} right by two.
                        hi_d    = {{2{sum[HW-1]}}, sum[HW-1:2]};
                        m_d     = {sum[1:0], m_q[EW-1:2]};
                        bprev_d = m_q[1];
                        cnt_d   = cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            m_q      <= '0;
            bprev_q  <= 1'b0;
            hi_q     <= '0;
            cnt_q    <= '0;
            signed_q <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            m_q      <= m_d;
            bprev_q  <= bprev_d;
            hi_q     <= hi_d;
            cnt_q    <= cnt_d;
            signed_q <= signed_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign overflow  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_radix4_booth_mult.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_radix4_booth_mult
//  Purpose  : Self-checking bench for seq_radix4_booth_mult (N=32): directed
//             corner products, latency, backpressure, flush, async reset and
//             a randomized streaming run against an arithmetic reference.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_radix4_booth_mult;

    localparam int N    = 32;
    localparam int NOPS = 1500;
    localparam longint SMAX = 64'sh0000_0000_7FFF_FFFF;
    localparam longint SMIN = -64'sh0000_0000_8000_0000;

    logic           clk;
    logic           reset;
    logic           flush;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   in_a;
    logic [N-1:0]   in_b;
    logic           in_signed;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] result;
    logic           overflow;

    int n_cmp = 0;
    int n_err = 0;

    seq_radix4_booth_mult #(.N(N)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_signed (in_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain integer multiply; returns {overflow, product}.
    function automatic logic [64:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
        longint     p;
        logic [63:0] r;
        logic        ov;
        if (s) begin
            p  = longint'($signed(a)) * longint'($signed(b));
            r  = p;
            ov = (p > SMAX) || (p < SMIN);
        end else begin
            r  = {32'd0, a} * {32'd0, b};
            ov = (r[63:32] != 32'd0);
        end
        return {ov, r};
    endfunction

    function automatic logic [31:0] rnd_operand();
        logic [31:0] corners [5];
        corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        if ($urandom_range(3) == 0) return corners[$urandom_range(4)];
        return $urandom;
    endfunction

    // Present operands once in_ready is seen; afterwards flip in_signed to
    // show the mode is latched at accept.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
        int g;
        g = 0;
        while (!in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk("start_ready", 64'(in_ready), 64'd1);
        in_a      = a;
        in_b      = b;
        in_signed = s;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        in_signed = ~s;
    endtask

    // Edges from the accept edge until out_valid is observed.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic s);
        logic [64:0] e;
        int          lat;
        e = ref_mul(a, b, s);
        start_op(a, b, s);
        wait_valid(lat);
        chk({tag, "_lat"}, 64'(lat), 64'd18);
        chk({tag, "_res"}, result, e[63:0]);
        chk({tag, "_ovf"}, 64'(overflow), 64'(e[64]));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_idle"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [64:0] e;
        logic [63:0] snap;
        logic        seen;
        int          lat;
        int          acc_n;
        int          done_n;
        logic [64:0] q[$];

        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_signed = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result",    result,         64'd0);
        chk("rst_overflow",  64'(overflow),  64'd0);
        reset = 1'b1;
        @(negedge clk);

        // Directed corner products
        directed("s_m1m1",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        chk("s_m1m1_val", result, 64'h0000_0000_0000_0001);
        directed("s_minmin", 32'h8000_0000, 32'h8000_0000, 1'b1);
        chk("s_minmin_val", result, 64'h4000_0000_0000_0000);
        directed("u_maxmax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        chk("u_maxmax_val", result, 64'hFFFF_FFFE_0000_0001);
        directed("s_7m3", 32'd7, 32'hFFFF_FFFD, 1'b1);
        chk("s_7m3_val", result, 64'hFFFF_FFFF_FFFF_FFEB);
        directed("u_7x3", 32'd7, 32'd3, 1'b0);
        chk("u_7x3_val", result, 64'h15);

        // Backpressure: hold DONE for 10 cycles with a competing in_valid
        e = ref_mul(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        start_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        wait_valid(lat);
        chk("bp_res0", result, e[63:0]);
        snap     = result;
        in_a     = 32'd1;
        in_b     = 32'd1;
        in_valid = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("bp_res",   result,          snap);
            chk("bp_inrdy", 64'(in_ready),   64'd0);
            chk("bp_valid", 64'(out_valid),  64'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_idle",  64'(in_ready),  64'd1);
        chk("bp_vlow",  64'(out_valid), 64'd0);
        seen = 1'b0;
        repeat (25) begin
            @(negedge clk);
            seen |= out_valid;
        end
        chk("bp_no_extra_op", 64'(seen), 64'd0);

        // Flush in the middle of CALC
        snap = result;
        start_op(32'd5, 32'd9, 1'b0);
        repeat (5) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("fl_inrdy", 64'(in_ready),  64'd1);
        chk("fl_valid", 64'(out_valid), 64'd0);
        seen = 1'b0;
        repeat (25) begin
            @(negedge clk);
            seen |= out_valid;
        end
        chk("fl_never_valid", 64'(seen), 64'd0);
        chk("fl_res_held",    result,    snap);

        // Asynchronous reset mid-CALC, away from any clock edge
        start_op(32'd11, 32'd13, 1'b0);
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("ar_inrdy", 64'(in_ready),  64'd1);
        chk("ar_valid", 64'(out_valid), 64'd0);
        chk("ar_res",   result,         64'd0);
        chk("ar_ovf",   64'(overflow),  64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        directed("after_rst", 32'd3, 32'd5, 1'b0);
        chk("after_rst_val", result, 64'hF);

        // Randomized streaming with random in_valid / out_ready
        acc_n  = 0;
        done_n = 0;
        for (int cyc = 0; cyc < 80000 && done_n < NOPS; cyc++) begin
            in_a      = rnd_operand();
            in_b      = rnd_operand();
            in_signed = 1'($urandom_range(1));
            in_valid  = (acc_n < NOPS) && ($urandom_range(9) < 7);
            out_ready = ($urandom_range(9) < 6);
            if (in_valid && in_ready) begin
                q.push_back(ref_mul(in_a, in_b, in_signed));
                acc_n++;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("rnd_unexpected_out", 64'(out_valid), 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("rnd_res", result, e[63:0]);
                    chk("rnd_ovf", 64'(overflow), 64'(e[64]));
                end
                done_n++;
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("rnd_done_count", 64'(done_n), 64'(NOPS));
        chk("rnd_lost",       64'(q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
